prog_mem_loader: RTL and testbench

//  Writer side of the program memory: receives a byte stream (e.g. from a UART RX) carrying a length-prefixed program image.

---
 rtl/prog_mem_loader_pkg.sv | 43 ++++
 rtl/prog_mem_loader.sv | 176 +++++++++++++++++
 tb/tb_prog_mem_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loader_pkg
//  Description : Shared definitions for the program-memory loader. These
//                are the loader state encoding and the image magic word.
//                The CPU boot check uses the same magic constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_loader_pkg;

    // Image magic "ASRM". It is stored and streamed most-significant byte first.
    localparam logic [31:0] C_MAGIC = 32'h4153524d;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_MAGIC  = 3'd3,
        S_DATA   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_MAGIC) || (s == S_DATA);
    endfunction

    // Expected magic byte for image byte index 0..3. Index 0 is the MSB.
    function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
        logic [7:0] b;
        b = magic[7:0];
        case (idx)
            2'd0:    b = magic[31:24];
            2'd1:    b = magic[23:16];
            2'd2:    b = magic[15:8];
            default: b = magic[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loader
//  Description : Writer side of the CPU program RAM. The loader takes a byte
//                stream laid out as LEN_LO, LEN_HI, then LEN image bytes.
//                The image bytes begin with the 4-byte magic. The loader
//                checks the magic and writes each image byte to RAM. It holds
//                the CPU in reset until a complete, valid image is in RAM.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start             - 1-cycle pulse, begins a load from
//                                    IDLE/DONE/ERROR
//                in_data/in_valid/in_ready - byte stream handshake
//                mem_addr/mem_data/mem_we  - RAM write port (registered)
//                cpu_hold          - CPU reset hold
//                done / error      - sticky status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int          ADDR_W = 9,
    parameter logic [31:0] MAGIC  = C_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // The counter has one extra bit. A full-capacity image then ends at 2**ADDR_W without wrapping.
    localparam int          CNT_W      = ADDR_W + 1;
    localparam logic [16:0] C_CAPACITY = 17'd1 << ADDR_W;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_in_ready;
    logic               r_mem_we;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_data;
    logic [15:0]        r_len;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_xfer;
    logic               w_start;
    logic               w_write;
    logic               w_last;
    logic               w_len_bad;
    logic               w_set_done;
    logic               w_set_error;
    logic [15:0]        w_len_full;
    logic [7:0]         w_magic_byte;

    assign w_xfer       = in_valid & r_in_ready;
    // In LEN_HI the length is incomplete. The high byte is still on in_data.
    assign w_len_full   = {in_data, r_len[7:0]};
    assign w_len_bad    = (w_len_full < 16'd4) || ({1'b0, w_len_full} > C_CAPACITY);
    assign w_last       = ({{(16-CNT_W){1'b0}}, r_cnt} == (r_len - 16'd1));
    assign w_magic_byte = magic_byte(MAGIC, r_cnt[1:0]);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_set_done   = 1'b0;
        w_set_error  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_next = S_LEN_LO;
                    w_start      = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_bad) begin
                        w_state_next = S_ERROR;
                        w_set_error  = 1'b1;
                    end else begin
                        w_state_next = S_MAGIC;
                    end
                end
            end
            S_MAGIC: begin
                if (w_xfer) begin
                    if (in_data != w_magic_byte) begin
                        // A mismatching byte is never written.
                        w_state_next = S_ERROR;
                        w_set_error  = 1'b1;
                    end else begin
                        w_write = 1'b1;
                        if (w_last) begin
                            w_state_next = S_DONE;
                            w_set_done   = 1'b1;
                        end else if (r_cnt[1:0] == 2'd3) begin
                            w_state_next = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_write = 1'b1;
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_set_done   = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            // in_ready is a register driven from the next state. It has no path from in_valid.
            r_in_ready <= accepts_bytes(w_state_next);
            r_mem_we   <= w_write;
            if (w_write) begin
                r_mem_addr <= r_cnt[ADDR_W-1:0];
                r_mem_data <= in_data;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_LEN_LO) && w_xfer) r_len[7:0]  <= in_data;
            if ((r_state == S_LEN_HI) && w_xfer) r_len[15:8] <= in_data;
            if (w_start) begin
                r_cnt      <= '0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_cpu_hold <= 1'b1;
            end
            // done and the release of cpu_hold appear in the same cycle as the final mem_we.
            if (w_set_done) begin
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
            end
            // On error cpu_hold stays set, so the CPU never runs a partial image.
            if (w_set_error) r_error <= 1'b1;
        end
    end

    assign in_ready = r_in_ready;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_mem_loader
//  Description : Self-checking directed testbench for prog_mem_loader.
//                Inputs change only on the falling clock edge. A monitor
//                logs every RAM write and flags writes that have no
//                transfer on the edge before them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

    localparam int ADDR_W = 9;

    typedef logic [7:0] bq_t [$];

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int         checks   = 0;
    int         errors   = 0;
    int         spurious = 0;
    int         log_addr[$];
    logic [7:0] log_data[$];
    logic       ready_q  = 1'b0;

    bq_t c_img = '{8'h41, 8'h53, 8'h52, 8'h4d, 8'haa, 8'hbb};
    bq_t c_s1  = '{8'h06, 8'h00, 8'h41, 8'h53, 8'h52, 8'h4d, 8'haa, 8'hbb};

    always #5 clk = ~clk;

    prog_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    // The write monitor samples 1 time unit after each rising edge. in_valid changes
    // only on falling edges, and ready_q holds the in_ready value seen at this edge.
    always @(posedge clk) begin
        #1;
        if (mem_we) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(mem_data);
            if (!(in_valid && ready_q)) spurious++;
        end
        ready_q = in_ready;
    end

    // Call at a falling edge. Returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout byte=%02h in_ready=%b required 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_stream(input bq_t q, input bit gap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap && i != q.size() - 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        spurious = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b we=%b addr=%0d data=%02h hold=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%b we=%b hold=%b done=%b err=%b required 0",
                     in_ready, mem_we, cpu_hold, done, error);
        end
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        checks++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start got hold=%b rdy=%b required 1 1", cpu_hold, in_ready);
        end
        send_stream(c_s1, 1'b0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 9'd5 || mem_data !== 8'hbb || done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_final got we=%b addr=%0d data=%02h done=%b hold=%b err=%b required 1 5 bb 1 0 0",
                     mem_we, mem_addr, mem_data, done, cpu_hold, error);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_after got rdy=%b we=%b done=%b required 0 0 1", in_ready, mem_we, done);
        end
        checks++;
        if (log_addr.size() !== 6) begin
            errors++;
            $display("FAIL basic_count got %0d required 6", log_addr.size());
        end else begin
            foreach (c_img[i]) begin
                checks++;
                if (log_addr[i] !== i || log_data[i] !== c_img[i]) begin
                    errors++;
                    $display("FAIL basic_write[%0d] got addr=%0d data=%02h required addr=%0d data=%02h",
                             i, log_addr[i], log_data[i], i, c_img[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        clear_log();
        pulse_start();
        send_stream(c_s1, 1'b1);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 9'd5) begin
            errors++;
            $display("FAIL gaps_final got done=%b hold=%b we=%b addr=%0d required 1 0 1 5", done, cpu_hold, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL gaps_spurious got %0d writes without transfer required 0", spurious);
        end
        checks++;
        if (log_addr.size() !== 6) begin
            errors++;
            $display("FAIL gaps_count got %0d required 6", log_addr.size());
        end else begin
            foreach (c_img[i]) begin
                checks++;
                if (log_addr[i] !== i || log_data[i] !== c_img[i]) begin
                    errors++;
                    $display("FAIL gaps_write[%0d] got addr=%0d data=%02h required addr=%0d data=%02h",
                             i, log_addr[i], log_data[i], i, c_img[i]);
                end
            end
        end
    endtask

    task automatic test_bad_magic();
        bq_t s;
        s = '{8'h08, 8'h00, 8'h41, 8'h53, 8'h00};
        clear_log();
        pulse_start();
        send_stream(s, 1'b0);
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL magic_err got err=%b hold=%b rdy=%b we=%b done=%b required 1 1 0 0 0",
                     error, cpu_hold, in_ready, mem_we, done);
        end
        in_valid = 1'b1; in_data = 8'h52;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (log_addr.size() !== 2 || log_addr[0] !== 0 || log_data[0] !== 8'h41 || log_addr[1] !== 1 || log_data[1] !== 8'h53) begin
            errors++;
            $display("FAIL magic_writes got %0d writes required 2 (0:41 1:53)", log_addr.size());
        end
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL magic_sticky got err=%b rdy=%b required 1 0", error, in_ready);
        end
    endtask

    task automatic test_len_bounds();
        bq_t s;
        int  bad_idx;
        clear_log();
        pulse_start();
        s = '{8'h03, 8'h00};
        send_stream(s, 1'b0);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL len3 got err=%b rdy=%b hold=%b required 1 0 1", error, in_ready, cpu_hold);
        end
        pulse_start();
        s = '{8'h01, 8'h02};
        send_stream(s, 1'b0);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len201 got err=%b rdy=%b required 1 0", error, in_ready);
        end
        @(negedge clk);
        checks++;
        if (log_addr.size() !== 0) begin
            errors++;
            $display("FAIL len_nowrite got %0d writes required 0", log_addr.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_restart got err=%b rdy=%b required 0 1", error, in_ready);
        end
        s = '{8'h00, 8'h02, 8'h41, 8'h53, 8'h52, 8'h4d};
        for (int a = 4; a < 512; a++) s.push_back(8'(a) ^ 8'h5a);
        send_stream(s, 1'b0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || mem_addr !== 9'h1ff || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL len200_final got done=%b err=%b addr=%0h hold=%b required 1 0 1ff 0", done, error, mem_addr, cpu_hold);
        end
        @(negedge clk);
        bad_idx = -1;
        for (int a = 0; a < 512 && a < log_addr.size(); a++) begin
            if (bad_idx < 0 && (log_addr[a] !== a || log_data[a] !== s[a+2])) bad_idx = a;
        end
        checks++;
        if (log_addr.size() !== 512 || bad_idx !== -1) begin
            errors++;
            $display("FAIL len200_fill got %0d writes first_bad=%0d required 512 writes first_bad=-1", log_addr.size(), bad_idx);
        end
    endtask

    task automatic test_reset_mid();
        bq_t s;
        s = '{8'h08, 8'h00, 8'h41, 8'h53, 8'h52, 8'h4d, 8'haa, 8'hbb, 8'hcc};
        pulse_start();
        send_stream(s, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error} !== '0) begin
            errors++;
            $display("FAIL midreset got rdy=%b we=%b addr=%0d data=%02h hold=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error);
        end
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_stream(c_s1, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || log_addr.size() !== 6) begin
            errors++;
            $display("FAIL midreset_reload got done=%b writes=%0d required 1 6", done, log_addr.size());
        end else begin
            foreach (c_img[i]) begin
                checks++;
                if (log_addr[i] !== i || log_data[i] !== c_img[i]) begin
                    errors++;
                    $display("FAIL midreset_write[%0d] got addr=%0d data=%02h required addr=%0d data=%02h",
                             i, log_addr[i], log_data[i], i, c_img[i]);
                end
            end
        end
    endtask

    task automatic test_start_effects();
        bq_t s;
        clear_log();
        pulse_start();
        s = '{8'h06, 8'h00, 8'h41, 8'h53, 8'h52, 8'h4d, 8'haa};
        send_stream(s, 1'b0);
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_data got rdy=%b hold=%b done=%b required 1 1 0", in_ready, cpu_hold, done);
        end
        s = '{8'hbb};
        send_stream(s, 1'b0);
        checks++;
        if (done !== 1'b1 || mem_addr !== 9'd5 || mem_data !== 8'hbb) begin
            errors++;
            $display("FAIL start_ignored_final got done=%b addr=%0d data=%02h required 1 5 bb", done, mem_addr, mem_data);
        end
        @(negedge clk);
        checks++;
        if (log_addr.size() !== 6) begin
            errors++;
            $display("FAIL start_ignored_count got %0d required 6", log_addr.size());
        end else begin
            foreach (c_img[i]) begin
                checks++;
                if (log_addr[i] !== i || log_data[i] !== c_img[i]) begin
                    errors++;
                    $display("FAIL start_ignored_write[%0d] got addr=%0d data=%02h required addr=%0d data=%02h",
                             i, log_addr[i], log_data[i], i, c_img[i]);
                end
            end
        end
        pulse_start();
        s = '{8'h06, 8'h00, 8'h41, 8'h00};
        send_stream(s, 1'b0);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL err_entry got err=%b required 1", error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_restart got err=%b hold=%b rdy=%b done=%b required 0 1 1 0", error, cpu_hold, in_ready, done);
        end
        clear_log();
        send_stream(c_s1, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || log_addr.size() !== 6) begin
            errors++;
            $display("FAIL err_reload got done=%b err=%b hold=%b writes=%0d required 1 0 0 6",
                     done, error, cpu_hold, log_addr.size());
        end else begin
            checks++;
            if (log_addr[5] !== 5 || log_data[5] !== 8'hbb || log_data[0] !== 8'h41) begin
                errors++;
                $display("FAIL err_reload_data got a5=%0d d5=%02h d0=%02h required 5 bb 41", log_addr[5], log_data[5], log_data[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bad_magic();
        test_len_bounds();
        test_reset_mid();
        test_start_effects();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
